// File: rtl/binary_search_param_pkg.sv
// Shared types for the parametrised binary-search engine.
package bsearch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } bsearch_state_t;

    typedef enum logic {
        EXACT       = 1'b0,
        LOWER_BOUND = 1'b1
    } bsearch_mode_t;

    // Wide enough to hold MEM_LAT-1 for the largest supported latency (4).
    localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/binary_search_param_lat_ctr.sv
// Read-latency down-counter: loaded on each probe issue, flags the last wait cycle
// so the FSM enters COMPARE exactly when mem_q becomes valid.
module bsearch_lat_ctr #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic wait_done
);
    import bsearch_pkg::*;

    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LAT_CNT_W'(MEM_LAT - 1);
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wait_done = (cnt_q <= LAT_CNT_W'(1));

endmodule

// File: rtl/binary_search_param.sv
// Binary search over an external sorted synchronous-read memory; exact-match or
// lower-bound mode, reporting index, hit flag and number of probes.
module binary_search_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic                          Mode,
    input  logic [DATA_W-1:0]             A,
    input  logic [DATA_W-1:0]             mem_q,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_rd,
    output logic [ADDR_W:0]               Loc,
    output logic                          Found,
    output logic                          Done,
    output logic [$clog2(ADDR_W+2)-1:0]   Probes
);
    import bsearch_pkg::*;

    localparam int unsigned PW = $clog2(ADDR_W + 2);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    bsearch_state_t       state_q, state_d;
    bsearch_mode_t        mode_q, mode_d;
    logic [DATA_W-1:0]    key_q, key_d;
    logic [ADDR_W:0]      lo_q, lo_d, hi_q, hi_d;
    logic                 hit_q, hit_d;
    logic [PW-1:0]        probes_q, probes_d;

    logic [ADDR_W+1:0]    sum;
    logic [ADDR_W-1:0]    mid;
    logic [ADDR_W:0]      mid_p1;
    logic                 lat_wait_done;

    // Extra sum bit keeps lo+hi from wrapping when hi == DEPTH.
    assign sum    = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid    = ADDR_W'(sum >> 1);
    assign mid_p1 = {1'b0, mid} + (ADDR_W+1)'(1);

    bsearch_lat_ctr #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_ctr (
        .clk       (clk),
        .rst       (Reset),
        .load      (state_q == ISSUE),
        .dec       (state_q == WAIT),
        .wait_done (lat_wait_done)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        key_d    = key_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        hit_d    = hit_q;
        probes_d = probes_q;
        mem_rd   = 1'b0;
        mem_addr = '0;

        case (state_q)
            IDLE: begin
                lo_d     = '0;
                hi_d     = DEPTH;
                hit_d    = 1'b0;
                probes_d = '0;
                if (Start) begin
                    key_d   = A;
                    mode_d  = bsearch_mode_t'(Mode);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = mid;
                probes_d = probes_q + PW'(1);
                state_d  = (MEM_LAT > 1) ? WAIT : COMPARE;
            end
            WAIT: begin
                if (lat_wait_done) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (mem_q < key_q) begin
                    lo_d = mid_p1;
                end else begin
                    hi_d = {1'b0, mid};
                    if (mem_q == key_q) begin
                        hit_d = 1'b1;
                    end
                end
                if (mode_q == EXACT && mem_q == key_q) begin
                    lo_d    = {1'b0, mid};
                    state_d = DONE;
                end else if (lo_d == hi_d) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            DONE: begin
                // Results clear on the same edge that returns to IDLE.
                if (!Start) begin
                    lo_d     = '0;
                    hi_d     = DEPTH;
                    hit_d    = 1'b0;
                    probes_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            mode_q   <= EXACT;
            key_q    <= '0;
            lo_q     <= '0;
            hi_q     <= DEPTH;
            hit_q    <= 1'b0;
            probes_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            key_q    <= key_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            hit_q    <= hit_d;
            probes_q <= probes_d;
        end
    end

    assign Done   = (state_q == DONE);
    assign Loc    = Done ? lo_q : '0;
    assign Found  = Done & hit_q;
    assign Probes = probes_q;

endmodule

// File: tb/tb_binary_search_param.sv
// Directed bench: table of searches on a MEM_LAT=1 instance, plus hand sequences
// for duplicates, MEM_LAT=3 timing and reset mid-search.
module tb_binary_search_param;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst1, start1, mode1, rd1, found1, done1;
    logic [DW-1:0] a1, q1;
    logic [AW-1:0] addr1;
    logic [AW:0]   loc1;
    logic [2:0]    probes1;

    logic          rst3, start3, mode3, rd3, found3, done3;
    logic [DW-1:0] a3, q3;
    logic [AW-1:0] addr3;
    logic [AW:0]   loc3;
    logic [2:0]    probes3;

    logic [DW-1:0] mem1 [32];
    logic [DW-1:0] mem3 [32];
    logic [DW-1:0] pipe3 [3];

    binary_search_param #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) dut1 (
        .clk(clk), .Reset(rst1), .Start(start1), .Mode(mode1), .A(a1), .mem_q(q1),
        .mem_addr(addr1), .mem_rd(rd1), .Loc(loc1), .Found(found1), .Done(done1),
        .Probes(probes1)
    );

    binary_search_param #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(3)) dut3 (
        .clk(clk), .Reset(rst3), .Start(start3), .Mode(mode3), .A(a3), .mem_q(q3),
        .mem_addr(addr3), .mem_rd(rd3), .Loc(loc3), .Found(found3), .Done(done3),
        .Probes(probes3)
    );

    // Behavioural sync-read memories with 1 and 3 cycles of latency.
    always @(posedge clk) q1 <= mem1[addr1];
    always @(posedge clk) begin
        pipe3[0] <= mem3[addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign q3 = pipe3[2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit l3, input logic s, input logic m, input logic [DW-1:0] k);
        if (l3) begin
            rst3 = 1'b0; start3 = s; mode3 = m; a3 = k;
        end else begin
            rst1 = 1'b0; start1 = s; mode1 = m; a1 = k;
        end
    endtask

    function automatic int g_done(input bit l3);   return l3 ? int'(done3)   : int'(done1);   endfunction
    function automatic int g_found(input bit l3);  return l3 ? int'(found3)  : int'(found1);  endfunction
    function automatic int g_loc(input bit l3);    return l3 ? int'(loc3)    : int'(loc1);    endfunction
    function automatic int g_probes(input bit l3); return l3 ? int'(probes3) : int'(probes1); endfunction
    function automatic int g_rd(input bit l3);     return l3 ? int'(rd3)     : int'(rd1);     endfunction

    // One full search: start, wait for Done (bounded), check results/timing/strobe
    // pattern, hold in DONE, then release back to IDLE.
    task automatic run_search(input bit l3, input logic m, input logic [DW-1:0] k,
                              input string tag, input int loc_lo, input int loc_hi,
                              input int exp_found, input int exp_probes);
        int lat;
        int edges;
        int rd_n;
        int rd_bad;
        int loc;
        lat    = l3 ? 3 : 1;
        edges  = -1;
        rd_n   = 0;
        rd_bad = 0;
        @(negedge clk);
        drive(l3, 1'b1, m, k);
        @(posedge clk); #1;
        if (g_rd(l3) != 0) rd_n++;
        if (g_rd(l3) != 1) rd_bad++;
        @(negedge clk);
        drive(l3, 1'b1, ~m, ~k);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (g_done(l3) == 1) begin
                edges = n;
                break;
            end
            if (g_rd(l3) != 0) rd_n++;
            if (g_rd(l3) != ((n % (lat + 1)) == 0 ? 1 : 0)) rd_bad++;
        end
        loc = g_loc(l3);
        check({tag, " done_edges"}, edges, exp_probes * (lat + 1));
        if (loc_lo == loc_hi) check({tag, " loc"}, loc, loc_lo);
        else check({tag, " loc_in_range"}, (loc >= loc_lo && loc <= loc_hi) ? 1 : 0, 1);
        check({tag, " found"}, g_found(l3), exp_found);
        check({tag, " probes"}, g_probes(l3), exp_probes);
        check({tag, " rd_count"}, rd_n, exp_probes);
        check({tag, " rd_pattern_errs"}, rd_bad, 0);
        @(posedge clk); #1;
        check({tag, " done_held"}, g_done(l3), 1);
        check({tag, " found_held"}, g_found(l3), exp_found);
        @(negedge clk);
        drive(l3, 1'b0, m, k);
        @(posedge clk); #1;
        check({tag, " done_cleared"}, g_done(l3), 0);
        check({tag, " loc_cleared"}, g_loc(l3), 0);
        check({tag, " probes_cleared"}, g_probes(l3), 0);
    endtask

    typedef struct {
        logic          mode;
        logic [DW-1:0] key;
        int            loc;
        int            found;
        int            probes;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 8'd211, 26, 1, 4};
        vecs[1] = '{1'b1, 8'd0,    0, 0, 6};
        vecs[2] = '{1'b1, 8'd255, 32, 0, 5};
        vecs[3] = '{1'b0, 8'd100, 13, 0, 5};
        vecs[4] = '{1'b1, 8'd211, 26, 1, 5};
        vecs[5] = '{1'b1, 8'd5,    1, 0, 6};
        vecs[6] = '{1'b0, 8'd3,    0, 1, 6};
        vecs[7] = '{1'b0, 8'd251, 31, 1, 5};

        for (int i = 0; i < 32; i++) begin
            mem1[i] = 8'(8 * i + 3);
            mem3[i] = 8'(8 * i + 3);
        end
        rst1 = 1'b1; start1 = 1'b0; mode1 = 1'b0; a1 = '0;
        rst3 = 1'b1; start3 = 1'b0; mode3 = 1'b0; a3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset done1", int'(done1), 0);
        check("reset loc1", int'(loc1), 0);
        check("reset probes1", int'(probes1), 0);
        check("reset rd1", int'(rd1), 0);
        check("reset done3", int'(done3), 0);
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_search(1'b0, vecs[i].mode, vecs[i].key, $sformatf("vec%0d", i),
                       vecs[i].loc, vecs[i].loc, vecs[i].found, vecs[i].probes);
        end

        @(negedge clk);
        for (int i = 10; i <= 13; i++) mem1[i] = 8'd100;
        run_search(1'b0, 1'b1, 8'd100, "dup_lb", 10, 10, 1, 5);
        run_search(1'b0, 1'b0, 8'd100, "dup_exact", 10, 13, 1, 3);

        run_search(1'b1, 1'b0, 8'd211, "lat3_exact", 26, 26, 1, 4);

        // Reset while the MEM_LAT=3 instance sits in WAIT.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 8'd211);
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_rst in_wait rd3", int'(rd3), 0);
        @(negedge clk);
        rst3 = 1'b1; a3 = 8'd35; mode3 = 1'b0; start3 = 1'b1;
        @(posedge clk); #1;
        check("rst_mid done3", int'(done3), 0);
        check("rst_mid found3", int'(found3), 0);
        check("rst_mid loc3", int'(loc3), 0);
        check("rst_mid probes3", int'(probes3), 0);
        check("rst_mid rd3", int'(rd3), 0);
        check("rst_mid addr3", int'(addr3), 0);
        @(posedge clk); #1;
        check("rst_hold rd3", int'(rd3), 0);
        run_search(1'b1, 1'b0, 8'd35, "rst_fresh", 4, 4, 1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
